decoder_select_arbiter: RTL and testbench
=========================================

# decoder_select_arbiter

Round-robin arbiter that shares one 3-to-8 decoded select resource among eight requesters. Each cycle it chooses at most one requester and drives a registered 3-bit index, plus its one-hot decoded form, to the downstream select fabric. The block bounds how long any requester can hold the grant and inserts one idle gap between grants so that decoded selects never overlap. It sits between the requesting agents and the decoder-driven select lines.

## Interface
- MAX_HOLD, 16, maximum consecutive grant cycles per tenure; legal range 1..255; the hold counter is 8 bits wide.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  arbitration enable; while low, no new grant is issued, but the current tenure continues normally.
- req  input  8  level requests; bit i belongs to requester i.
- grant_valid  output  1  high while a grant is held.
- grant_idx  output  3  index of the granted requester; holds its last value when grant_valid=0.
- grant_onehot  output  8  (1 << grant_idx) when grant_valid=1, otherwise 8'h00.
- preempt  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD rather than by a request drop.

## Operation
- There are three states:
  - IDLE: no grant is held.
  - GRANT: a requester holds the select.
  - GAP: a mandatory single dead cycle after every tenure.
- Internal registers:
  - ptr[2:0]: round-robin priority pointer.
  - hold_cnt[7:0]: cycles spent in the current tenure.
- Arbitration is evaluated in IDLE and in GAP, and only when en=1 and req != 0:
  - Winner = first set bit of req, scanning ptr, ptr+1, …, ptr+7 modulo 8. The index wraps from 7 to 0.
  - Next state = GRANT; grant_idx <= winner; hold_cnt <= 1.
- GRANT behaviour:
  - If req[grant_idx]=0, next state = GAP, and preempt stays 0.
  - Else if hold_cnt == MAX_HOLD, next state = GAP and preempt=1 for exactly the first GAP cycle.
  - Otherwise hold_cnt increments and the grant stays.
  - The request-drop check has priority when both conditions are true in the same cycle, so preempt=0 in that case.
- On the transition GRANT→GAP: ptr <= grant_idx + 1 (mod 8). The finishing requester therefore gets lowest priority next.
- GAP behaviour:
  - grant_valid=0 for this cycle.
  - Arbitration is evaluated here, so if a winner exists the next state is GRANT directly, with no extra IDLE cycle.
  - If there is no winner, or en=0, the next state is IDLE.
- Requests from other requesters during GRANT are ignored; the tenure is never interrupted by a higher-priority request.
- en=0 during GRANT has no effect on that tenure. The block goes IDLE after GAP and stays IDLE until en=1.
- The decode is internal and registered: grant_onehot is a register updated together with grant_idx and grant_valid, not a combinational decode of them.

## Timing
- Reset (rst_n=0 sampled at a rising edge):
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant_valid=0, grant_idx=0, grant_onehot=8'h00, preempt=0.
  - Reset mid-tenure drops the grant at that edge with no GAP and no preempt pulse.
- Grant latency: a request sampled in IDLE at edge k gives grant_valid=1 after edge k, i.e. one cycle latency.
- Release latency:
  - If req[grant_idx] is sampled low at edge k, grant_valid=0 after edge k.
  - The earliest next grant is after edge k+1.
  - Minimum grant_valid low time between tenures is exactly 1 cycle.
- A tenure lasts at most MAX_HOLD cycles of grant_valid=1.
- With MAX_HOLD=1, every tenure is exactly one cycle, followed by GAP.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic grant and release:
  - Stimulus: reset, then req=8'h08 held for 3 cycles, then 0.
  - Required response: grant_idx=3, grant_onehot=8'h08 for 3 cycles starting one cycle after req rises; then 1 GAP cycle; final state IDLE; preempt never asserts.
- Round-robin fairness:
  - Stimulus: req=8'hFF held constantly, MAX_HOLD=2.
  - Required response: grants go 0,1,2,…,7,0 in order, each 2 cycles long, with one low cycle between them; preempt pulses after each tenure.
- Wrap and pointer:
  - Stimulus: after granting index 6, req=8'h41.
  - Required response: next grant goes to 0, not 6.
- Simultaneous drop and limit:
  - Stimulus: MAX_HOLD=4; the requester drops req in the 4th grant cycle.
  - Required response: preempt=0; grant ends after exactly 4 cycles.
- Enable gating:
  - Stimulus: en drops to 0 mid-tenure while req=8'h03.
  - Required response: the current tenure finishes, then no new grant is issued; when en returns to 1, a grant is issued one cycle later.
- Reset mid-tenure:
  - Stimulus: rst_n=0 for one edge while grant_idx=5 is active.
  - Required response: all outputs zero at that edge; ptr=0, so with req=8'h21 the next grant goes to 0.

Source files
------------

// File: rtl/decoder_select_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoded select among eight requesters.
// It bounds tenure length and inserts one dead cycle between grants.
module decoder_select_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic       grant_valid,
   output logic [2:0] grant_idx,
   output logic [7:0] grant_onehot,
   output logic       preempt
);

   localparam int unsigned N  = 8;
   localparam int unsigned IW = 3;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [IW-1:0] ptr, ptr_n;
   logic [CW-1:0] hold_cnt, hold_n;
   logic          valid_n;
   logic [IW-1:0] idx_n;
   logic [N-1:0]  onehot_n;
   logic          preempt_n;
   logic          win_found_c;
   logic [IW-1:0] win_idx_c;

   // First requester at or after ptr, wrapping 7 -> 0.
   always_comb begin
      win_found_c = 1'b0;
      win_idx_c   = ptr;
      for (int unsigned i = 0; i < N; i++) begin
         if (!win_found_c && req[ptr + IW'(i)]) begin
            win_found_c = 1'b1;
            win_idx_c   = ptr + IW'(i);
         end
      end
   end

   // Next-state and next registered outputs.
   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      hold_n    = hold_cnt;
      valid_n   = grant_valid;
      idx_n     = grant_idx;
      onehot_n  = grant_onehot;
      preempt_n = 1'b0;
      case (state)
         S_IDLE, S_GAP: begin
            state_n  = S_IDLE;
            valid_n  = 1'b0;
            onehot_n = '0;
            if (en && win_found_c) begin
               state_n  = S_GRANT;
               valid_n  = 1'b1;
               idx_n    = win_idx_c;
               onehot_n = N'(1) << win_idx_c;
               hold_n   = CW'(1);
            end
         end
         S_GRANT: begin
            // Request drop takes priority over the hold limit, so no preempt then.
            if (!req[grant_idx] || (hold_cnt == CW'(MAX_HOLD))) begin
               state_n   = S_GAP;
               valid_n   = 1'b0;
               onehot_n  = '0;
               ptr_n     = grant_idx + IW'(1);
               preempt_n = req[grant_idx];
            end else begin
               hold_n = hold_cnt + CW'(1);
            end
         end
         default: begin
            state_n  = S_IDLE;
            valid_n  = 1'b0;
            onehot_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         ptr          <= '0;
         hold_cnt     <= '0;
         grant_valid  <= 1'b0;
         grant_idx    <= '0;
         grant_onehot <= '0;
         preempt      <= 1'b0;
      end else begin
         state        <= state_n;
         ptr          <= ptr_n;
         hold_cnt     <= hold_n;
         grant_valid  <= valid_n;
         grant_idx    <= idx_n;
         grant_onehot <= onehot_n;
         preempt      <= preempt_n;
      end
   end

endmodule

// File: tb/tb_decoder_select_arbiter.sv
// Bench for decoder_select_arbiter: two instances (MAX_HOLD 2 and 4) share one
// stimulus stream and are checked every cycle against a tenure-level model.
module tb_decoder_select_arbiter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;

   logic       gv [2];
   logic [2:0] gi [2];
   logic [7:0] go [2];
   logic       gp [2];

   int n_cmp = 0;
   int n_err = 0;

   // Model: current owner (-1 when none), tenure length, rotating start point.
   int mh      [2] = '{2, 4};
   int m_owner [2] = '{-1, -1};
   int m_len   [2] = '{0, 0};
   int m_ptr   [2] = '{0, 0};
   int m_idx   [2] = '{0, 0};
   bit m_pre   [2] = '{0, 0};

   decoder_select_arbiter #(.MAX_HOLD(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .grant_valid(gv[0]), .grant_idx(gi[0]), .grant_onehot(go[0]), .preempt(gp[0])
   );

   decoder_select_arbiter #(.MAX_HOLD(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .grant_valid(gv[1]), .grant_idx(gi[1]), .grant_onehot(go[1]), .preempt(gp[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_owner[i] = -1; m_len[i] = 0; m_ptr[i] = 0; m_idx[i] = 0; m_pre[i] = 0;
         end else if (m_owner[i] >= 0) begin
            m_pre[i] = 0;
            if (!req[m_owner[i]] || m_len[i] == mh[i]) begin
               m_pre[i]   = req[m_owner[i]];
               m_ptr[i]   = (m_owner[i] + 1) % 8;
               m_owner[i] = -1;
            end else begin
               m_len[i]++;
            end
         end else begin
            m_pre[i] = 0;
            if (en && req != 8'h00) begin
               for (int k = 7; k >= 0; k--)
                  if (req[(m_ptr[i] + k) % 8]) m_owner[i] = (m_ptr[i] + k) % 8;
               m_idx[i] = m_owner[i];
               m_len[i] = 1;
            end
         end
      end
   endtask

   always @(posedge clk) model_step();

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         bit v;
         v = (m_owner[i] >= 0);
         check($sformatf("valid%0d", i), 32'(gv[i]), 32'(v));
         check($sformatf("idx%0d", i), 32'(gi[i]), 32'(m_idx[i]));
         check($sformatf("onehot%0d", i), 32'(go[i]), v ? (32'd1 << m_idx[i]) : 32'd0);
         check($sformatf("preempt%0d", i), 32'(gp[i]), 32'(m_pre[i]));
      end
   endtask

   // Apply inputs for one clock, then compare after the edge has settled.
   task automatic step(input logic [7:0] r, input logic e, input logic rn);
      req = r; en = e; rst_n = rn;
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int  k;
      bit  prev;
      logic [7:0] r;
      logic       e;

      // Reset state
      step(8'h00, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b0);
      check("rst_valid", 32'(gv[0]), 32'd0);
      check("rst_onehot", 32'(go[1]), 32'd0);

      // Basic grant and release
      step(8'h08, 1'b1, 1'b1);
      check("basic_idx", 32'(gi[1]), 32'd3);
      check("basic_onehot", 32'(go[1]), 32'h08);
      step(8'h08, 1'b1, 1'b1);
      step(8'h08, 1'b1, 1'b1);
      repeat (3) step(8'h00, 1'b1, 1'b1);
      check("basic_idle", 32'(gv[1]), 32'd0);

      // Round-robin order with all requesting (instance 0, MAX_HOLD=2)
      step(8'h00, 1'b1, 1'b0);
      k = 0; prev = 1'b0;
      repeat (27) begin
         step(8'hFF, 1'b1, 1'b1);
         if (gv[0] && !prev) begin
            check("rr_order", 32'(gi[0]), 32'(k % 8));
            k++;
         end
         prev = gv[0];
      end
      check("rr_tenures", 32'(k), 32'd9);
      repeat (2) step(8'h00, 1'b1, 1'b1);

      // Wrap: after index 6, 0 beats 6
      step(8'h00, 1'b1, 1'b0);
      step(8'h40, 1'b1, 1'b1);
      check("wrap_first", 32'(gi[1]), 32'd6);
      step(8'h00, 1'b1, 1'b1);
      step(8'h41, 1'b1, 1'b1);
      check("wrap_idx", 32'(gi[1]), 32'd0);
      repeat (2) step(8'h00, 1'b1, 1'b1);

      // Drop coincides with hold limit (instance 1, MAX_HOLD=4)
      step(8'h00, 1'b1, 1'b0);
      repeat (4) step(8'h01, 1'b1, 1'b1);
      check("drop_len_valid", 32'(gv[1]), 32'd1);
      step(8'h00, 1'b1, 1'b1);
      check("drop_preempt", 32'(gp[1]), 32'd0);
      check("drop_ended", 32'(gv[1]), 32'd0);
      step(8'h00, 1'b1, 1'b1);

      // Enable gating
      step(8'h03, 1'b1, 1'b1);
      repeat (8) step(8'h03, 1'b0, 1'b1);
      check("en_blocked", 32'(gv[1]), 32'd0);
      step(8'h03, 1'b1, 1'b1);
      check("en_regrant", 32'(gv[1]), 32'd1);
      repeat (3) step(8'h00, 1'b1, 1'b1);

      // Reset mid-tenure
      step(8'h20, 1'b1, 1'b1);
      check("mid_idx", 32'(gi[1]), 32'd5);
      step(8'h21, 1'b1, 1'b0);
      check("mid_rst_valid", 32'(gv[1]), 32'd0);
      check("mid_rst_idx", 32'(gi[1]), 32'd0);
      step(8'h21, 1'b1, 1'b1);
      check("mid_regrant", 32'(gi[1]), 32'd0);

      // Randomized traffic
      r = 8'h00;
      repeat (3000) begin
         if ($urandom_range(3) == 0) r = 8'($urandom);
         if ($urandom_range(7) == 0) r = 8'h00;
         e = ($urandom_range(7) != 0);
         step(r, e, ($urandom_range(99) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
